// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle for rv_muldiv_unit: issue handshake, operands, flush
// and the result handshake.
interface rv_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            is_word;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, is_word, rs1, rs2, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, is_word, rs1, rs2, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// RISC-V M-extension unit: single-cycle multiply stage and a radix-2 restoring
// divider producing one quotient bit per cycle, with optional RV64 W variants.
module rv_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit RV64_W_EN = (XLEN == 64)
) (
  input logic             clk,
  input logic             rst,
  rv_muldiv_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int         CW   = $clog2(XLEN) + 1;
  localparam bit         W_OK = RV64_W_EN && (XLEN == 64);

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
    return w ? {{(XLEN-31){x[31]}}, x[30:0]} : x;
  endfunction

  logic [1:0]      state;
  logic [1:0]      op;
  logic            word_q, q_neg, r_neg;
  logic [XLEN-1:0] a_q, b_q, rem, res_q;
  logic [CW-1:0]   cnt;

  // Request decode, evaluated on the live bus during IDLE
  logic            word_in, sgn_in, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_n, special;

  assign word_in = W_OK && bus.is_word;
  assign sgn_in  = !bus.funct3[0];
  assign a_ext   = !word_in ? bus.rs1 :
                   sgn_in   ? {{(XLEN-31){bus.rs1[31]}}, bus.rs1[30:0]} : XLEN'(bus.rs1[31:0]);
  assign b_ext   = !word_in ? bus.rs2 :
                   sgn_in   ? {{(XLEN-31){bus.rs2[31]}}, bus.rs2[30:0]} : XLEN'(bus.rs2[31:0]);
  assign a_neg   = bus.funct3[2] && sgn_in && a_ext[XLEN-1];
  assign b_neg   = bus.funct3[2] && sgn_in && b_ext[XLEN-1];
  assign mag_a   = a_neg ? -a_ext : a_ext;
  assign mag_b   = b_neg ? -b_ext : b_ext;
  assign min_n   = word_in ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div0    = (b_ext == '0);
  assign ovf     = sgn_in && (a_ext == min_n) && (b_ext == '1);
  assign special = wfix(word_in, div0 ? (bus.funct3[1] ? a_ext : '1)
                                      : (bus.funct3[1] ? '0 : a_ext));

  // Multiply: operands extended to 2*XLEN so one unsigned product covers all signedness mixes
  logic              a_s, b_s;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0]   mul_res;

  assign a_s     = (op != 2'b11);
  assign b_s     = (op == 2'b01);
  assign a_w     = {{XLEN{a_s && a_q[XLEN-1]}}, a_q};
  assign b_w     = {{XLEN{b_s && b_q[XLEN-1]}}, b_q};
  assign prod    = a_w * b_w;
  assign mul_res = wfix(word_q, (op != 2'b00 && !word_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);

  // Division step: a_q shifts the dividend out at the top and quotient bits in at the bottom
  logic [XLEN:0]   rem_sh, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fin, r_fin, div_res;
  logic [CW-1:0]   n_last;

  assign rem_sh  = {rem, a_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign q_bit   = !diff[XLEN];
  assign rem_nx  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {a_q[XLEN-2:0], q_bit};
  assign q_fin   = q_neg ? -quo_nx : quo_nx;
  assign r_fin   = r_neg ? -rem_nx : rem_nx;
  assign div_res = wfix(word_q, op[1] ? r_fin : q_fin);
  assign n_last  = word_q ? CW'(31) : CW'(XLEN-1);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      word_q <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rem    <= '0;
      res_q  <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op     <= bus.funct3[1:0];
          word_q <= word_in;
          cnt    <= '0;
          if (!bus.funct3[2]) begin
            a_q   <= a_ext;
            b_q   <= b_ext;
            state <= MUL;
          end else if (div0 || ovf) begin
            res_q <= special;
            state <= DONE;
          end else begin
            // Word dividends are left-aligned so 32 iterations consume exactly their bits
            a_q   <= word_in ? mag_a << (XLEN-32) : mag_a;
            b_q   <= mag_b;
            rem   <= '0;
            q_neg <= sgn_in && (a_neg ^ b_neg);
            r_neg <= a_neg;
            state <= DIV;
          end
        end
        MUL: begin
          res_q <= mul_res;
          state <= DONE;
        end
        DIV: begin
          a_q <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (cnt == n_last) begin
            res_q <= div_res;
            state <= DONE;
          end
        end
        default: if (bus.out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: XLEN=32 and XLEN=64 (W ops enabled)
// instances checked against a plain-arithmetic reference model.
module tb_rv_muldiv_unit;
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     rmode = 0;

  typedef struct {
    logic [63:0] exp;
    int          lat;
    longint      acc;
  } ent_t;

  ent_t   q32[$];
  ent_t   q64[$];
  bit     seen32 = 1'b0;
  bit     seen64 = 1'b0;

  rv_muldiv_unit_if #(.XLEN(32)) bus32();
  rv_muldiv_unit_if #(.XLEN(64)) bus64();

  rv_muldiv_unit #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .bus(bus32));
  rv_muldiv_unit #(.XLEN(64), .RV64_W_EN(1'b1)) u64 (.clk(clk), .rst(rst), .bus(bus64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: values as mathematical integers in 128 bits; / and % truncate toward zero
  function automatic logic [63:0] model(input int xl, input bit w, input logic [2:0] f,
                                        input logic [63:0] a, input logic [63:0] b,
                                        output int lat);
    int n;
    logic [127:0] m, ua, ub, p, r;
    logic signed [127:0] sa, sb, x, y, q, rm;
    n  = w ? 32 : xl;
    m  = (128'd1 << n) - 128'd1;
    ua = {64'b0, a} & m;
    ub = {64'b0, b} & m;
    sa = ua[n-1] ? $signed(ua - (128'd1 << n)) : $signed(ua);
    sb = ub[n-1] ? $signed(ub - (128'd1 << n)) : $signed(ub);
    if (!f[2]) begin
      lat = 2;
      case (f[1:0])
        2'b01:   p = sa * sb;
        2'b10:   p = sa * $signed(ub);
        default: p = ua * ub;
      endcase
      r = (f[1:0] != 2'b00 && !w) ? (p >> n) : p;
    end else begin
      x = f[0] ? $signed(ua) : sa;
      y = f[0] ? $signed(ub) : sb;
      if (ub == 0) begin
        q = -1; rm = x; lat = 1;
      end else if (!f[0] && ua == (128'd1 << (n-1)) && ub == m) begin
        q = x; rm = 0; lat = 1;
      end else begin
        q = x / y; rm = x % y; lat = n + 1;
      end
      r = f[1] ? rm : q;
    end
    r = r & m;
    if (w && r[31]) r = r | ~m;
    r = r & ((128'd1 << xl) - 128'd1);
    return r[63:0];
  endfunction

  function automatic logic [63:0] pick(input bit wide);
    logic [63:0] v;
    case ($urandom_range(0, 8))
      0: v = '0;
      1: v = '1;
      2: v = 64'd1;
      3: v = wide ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      4: v = 64'd7;
      5: v = {$urandom, 32'h8000_0000};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    bus32.out_ready = (rmode == 1) ? 1'b0 : (rmode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus64.out_ready = (rmode == 1) ? 1'b0 : (rmode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst) seen32 = 1'b0;
    else if (bus32.out_valid) begin
      if (q32.size() == 0) chk("spurious_valid32", {63'b0, bus32.out_valid}, 64'd0);
      else begin
        if (!seen32) begin
          seen32 = 1'b1;
          chk("latency32", 64'(cyc - q32[0].acc + 1), 64'(q32[0].lat));
        end
        chk("result32", {32'b0, bus32.result}, q32[0].exp);
        if (bus32.out_ready) begin void'(q32.pop_front()); seen32 = 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) seen64 = 1'b0;
    else if (bus64.out_valid) begin
      if (q64.size() == 0) chk("spurious_valid64", {63'b0, bus64.out_valid}, 64'd0);
      else begin
        if (!seen64) begin
          seen64 = 1'b1;
          chk("latency64", 64'(cyc - q64[0].acc + 1), 64'(q64[0].lat));
        end
        chk("result64", bus64.result, q64[0].exp);
        if (bus64.out_ready) begin void'(q64.pop_front()); seen64 = 1'b0; end
      end
    end
  end

  task automatic issue32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp, input int lat);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus32.in_valid = 1'b1; bus32.funct3 = f; bus32.rs1 = a; bus32.rs2 = b;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus32.in_ready) begin
        ok = 1'b1;
        if (push) q32.push_back('{exp, lat, cyc + 1});
      end
    end
    if (!ok) chk("accept_timeout32", {63'b0, bus32.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic issue64(input logic [2:0] f, input bit w, input logic [63:0] a, input logic [63:0] b,
                         input bit push, input logic [63:0] exp, input int lat);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus64.in_valid = 1'b1; bus64.funct3 = f; bus64.is_word = w; bus64.rs1 = a; bus64.rs2 = b;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus64.in_ready) begin
        ok = 1'b1;
        if (push) q64.push_back('{exp, lat, cyc + 1});
      end
    end
    if (!ok) chk("accept_timeout64", {63'b0, bus64.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && (q32.size() != 0 || q64.size() != 0); t++) @(negedge clk);
    if (q32.size() != 0 || q64.size() != 0) chk("drain_timeout", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [63:0] a, b, e;
    bit          w;
    int          lat;
    bit          got;

    bus32.in_valid = 1'b0; bus32.funct3 = '0; bus32.is_word = 1'b0;
    bus32.rs1 = '0; bus32.rs2 = '0; bus32.flush = 1'b0;
    bus64.in_valid = 1'b0; bus64.funct3 = '0; bus64.is_word = 1'b0;
    bus64.rs1 = '0; bus64.rs2 = '0; bus64.flush = 1'b0;

    #3;
    chk("rst_in_ready32", {63'b0, bus32.in_ready}, 64'd1);
    chk("rst_out_valid32", {63'b0, bus32.out_valid}, 64'd0);
    chk("rst_result32", {32'b0, bus32.result}, 64'd0);
    chk("rst_in_ready64", {63'b0, bus64.in_ready}, 64'd1);
    chk("rst_out_valid64", {63'b0, bus64.out_valid}, 64'd0);
    chk("rst_result64", bus64.result, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed XLEN=32 cases
    issue32(3'b001, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000, 2);
    issue32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFF, 2);
    issue32(3'b100, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFD, 33);
    issue32(3'b110, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF, 33);
    issue32(3'b101, 32'h0000_1234, 32'd0, 1, 64'hFFFF_FFFF, 1);
    issue32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0, 1);
    issue32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h8000_0000, 1);
    issue32(3'b111, 32'h0000_ABCD, 32'd0, 1, 64'h0000_ABCD, 1);
    drain();

    // Flush around iteration 10 of a divide
    issue32(3'b100, 32'd100000, 32'd7, 0, 64'd0, 0);
    repeat (9) @(posedge clk);
    #1 bus32.flush = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("flush_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    chk("flush_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    // flush together with a request in IDLE must not accept it
    bus32.in_valid = 1'b1; bus32.funct3 = 3'b100; bus32.rs1 = 32'd9; bus32.rs2 = 32'd3;
    @(negedge clk);
    chk("flush_blocks_accept", {63'b0, bus32.in_ready}, 64'd1);
    bus32.in_valid = 1'b0; bus32.flush = 1'b0;
    repeat (40) @(negedge clk);

    // Reset around iteration 5
    issue32(3'b101, 32'h0000_FFFF, 32'd3, 0, 64'd0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    chk("midrst_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    chk("midrst_result", {32'b0, bus32.result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    issue32(3'b000, 32'd3, 32'd5, 1, 64'd15, 2);
    drain();

    // Back-pressure: result held while out_ready is low
    rmode = 1;
    issue32(3'b000, 32'd7, 32'd6, 1, 64'd42, 2);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus32.out_valid;
    end
    chk("hold_reached_done", {63'b0, got}, 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {63'b0, bus32.out_valid}, 64'd1);
      chk("hold_result", {32'b0, bus32.result}, 64'd42);
    end
    rmode = 2;
    @(posedge clk); @(negedge clk); @(negedge clk);
    chk("release_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    chk("release_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    rmode = 0;

    // Randomised XLEN=32 traffic
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = {32'b0, pick(1'b0)};
      b = {32'b0, pick(1'b0)};
      e = model(32, 1'b0, f, a, b, lat);
      issue32(f, a[31:0], b[31:0], 1, e, lat);
    end
    drain();

    // Directed XLEN=64 cases
    issue64(3'b101, 1, 64'hFFFF_FFFF_8000_0000, 64'd1, 1, 64'hFFFF_FFFF_8000_0000, 33);
    issue64(3'b000, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    issue64(3'b100, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    issue64(3'b011, 0, '1, '1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    issue64(3'b100, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 1);
    issue64(3'b111, 1, 64'h1234_5678_8000_0001, 64'hABCD_0000_0000_0000, 1, 64'hFFFF_FFFF_8000_0001, 1);
    issue64(3'b110, 0, 64'h8000_0000_0000_0000, '1, 1, 64'd0, 1);
    drain();

    // Randomised XLEN=64 traffic, mixing W and full-width ops
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = pick(1'b1);
      b = pick(1'b1);
      e = model(64, w, f, a, b, lat);
      issue64(f, w, a, b, 1, e, lat);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
